// File: rtl/glenn_updown_stepgen.sv
// glenn_updown_stepgen: paced step/direction generator that walks a shadow position to a commanded target
module glenn_updown_stepgen #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 16
) (
    input  logic             in_Clk,
    input  logic             in_Reset_n,
    input  logic             in_Start,
    input  logic [WIDTH-1:0] in_Target,
    input  logic [DIV_W-1:0] in_Period,
    input  logic             in_Abort,
    output logic             out_Step,
    output logic             out_UporDown,
    output logic             out_Busy,
    output logic             out_Done,
    output logic [WIDTH-1:0] out_Position
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q, state_d;
    logic [WIDTH-1:0] tgt_q, tgt_d, pos_q, pos_d;
    logic [DIV_W-1:0] per_q, per_d, div_q, div_d;
    logic step_q, step_d, dir_q, dir_d, busy_q, busy_d, done_q, done_d;
    always_comb begin
        state_d = state_q;
        tgt_d = tgt_q;
        per_d = per_q;
        div_d = div_q;
        pos_d = pos_q;
        dir_d = dir_q;
        busy_d = busy_q;
        step_d = 1'b0;
        done_d = state_q == DONE;
        case (state_q)
            IDLE: if (in_Start) begin
                tgt_d = in_Target;
                per_d = in_Period == '0 ? DIV_W'(1) : in_Period;
                div_d = '0;
                state_d = in_Target != pos_q ? RUN : DONE;
                busy_d = in_Target != pos_q;
                dir_d = in_Target != pos_q ? in_Target > pos_q : dir_q;
            end
            RUN: if (in_Abort) begin
                state_d = DONE;
                busy_d = 1'b0;
            end else if (div_q == per_q - DIV_W'(1)) begin
                div_d = '0;
                step_d = 1'b1;
                // clamp at both rails to mirror the downstream saturating counter
                pos_d = dir_q ? (pos_q == {WIDTH{1'b1}} ? pos_q : pos_q + 1'b1)
                              : (pos_q == '0 ? pos_q : pos_q - 1'b1);
                state_d = pos_d == tgt_q ? DONE : RUN;
                busy_d = pos_d != tgt_q;
            end else begin
                div_d = div_q + 1'b1;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge in_Clk) begin
        if (!in_Reset_n) begin
            state_q <= IDLE;
            tgt_q <= '0;
            per_q <= '0;
            div_q <= '0;
            pos_q <= '0;
            dir_q <= 1'b0;
            busy_q <= 1'b0;
            step_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q <= tgt_d;
            per_q <= per_d;
            div_q <= div_d;
            pos_q <= pos_d;
            dir_q <= dir_d;
            busy_q <= busy_d;
            step_q <= step_d;
            done_q <= done_d;
        end
    end
    assign out_Step = step_q;
    assign out_UporDown = dir_q;
    assign out_Busy = busy_q;
    assign out_Done = done_q;
    assign out_Position = pos_q;
endmodule

// File: tb/tb_glenn_updown_stepgen.sv
// tb_glenn_updown_stepgen: directed moves plus random traffic against an elapsed-time move model
module tb_glenn_updown_stepgen;
    logic clk = 0, rst_n = 0, start = 0, abort = 0;
    logic [7:0] target = 0;
    logic [15:0] period = 0;
    logic out_Step, out_UporDown, out_Busy, out_Done;
    logic [7:0] out_Position;
    int checks = 0, errors = 0;
    int cyc = 0;
    bit started = 0;
    int m_state = 0, m_pos = 0, m_tgt = 0, m_pe = 1, m_t0 = 0;
    bit m_step = 0, m_dir = 0, m_busy = 0, m_done = 0;
    int step_q[$];
    int done_edge = -1;
    bit busy_seen = 0;
    int e0;

    always #5 clk = ~clk;

    glenn_updown_stepgen #(.WIDTH(8), .DIV_W(16)) dut (
        .in_Clk(clk), .in_Reset_n(rst_n), .in_Start(start), .in_Target(target),
        .in_Period(period), .in_Abort(abort), .out_Step(out_Step),
        .out_UporDown(out_UporDown), .out_Busy(out_Busy), .out_Done(out_Done),
        .out_Position(out_Position)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: a move started at edge t0 steps whenever the elapsed edge count is a multiple of the period
    always @(posedge clk) begin
        cyc++;
        started = 1;
        if (!rst_n) begin
            m_state = 0; m_pos = 0; m_step = 0; m_dir = 0; m_busy = 0; m_done = 0;
        end else begin
            m_step = 0;
            m_done = (m_state == 2);
            if (m_state == 0) begin
                if (start) begin
                    m_t0 = cyc;
                    m_pe = (period == 0) ? 1 : int'(period);
                    m_tgt = int'(target);
                    if (m_tgt != m_pos) begin
                        m_state = 1; m_busy = 1; m_dir = m_tgt > m_pos;
                    end else m_state = 2;
                end
            end else if (m_state == 1) begin
                if (abort) begin
                    m_state = 2; m_busy = 0;
                end else if ((cyc - m_t0) % m_pe == 0) begin
                    m_step = 1;
                    m_pos = m_dir ? (m_pos < 255 ? m_pos + 1 : m_pos) : (m_pos > 0 ? m_pos - 1 : 0);
                    if (m_pos == m_tgt) begin
                        m_state = 2; m_busy = 0;
                    end
                end
            end else m_state = 0;
        end
    end

    always @(negedge clk) if (started) begin
        check("step", out_Step, m_step);
        check("dir", out_UporDown, m_dir);
        check("busy", out_Busy, m_busy);
        check("done", out_Done, m_done);
        check("pos", out_Position, m_pos);
        if (out_Step) step_q.push_back(cyc);
        if (out_Done) done_edge = cyc;
        if (out_Busy) busy_seen = 1;
    end

    task automatic cyc_wait();
        @(negedge clk);
        #1;
    endtask

    task automatic start_move(input int t, input int p, output int e);
        cyc_wait();
        target = 8'(t);
        period = 16'(p);
        start = 1;
        e = cyc + 1;
        step_q.delete();
        done_edge = -1;
        busy_seen = 0;
        cyc_wait();
        start = 0;
    endtask

    task automatic wait_done(input int lim, input string nm);
        int n = 0;
        while (done_edge < 0 && n < lim) begin
            cyc_wait();
            n++;
        end
        if (done_edge < 0) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout, no done within %0d cycles", nm, lim);
        end
    endtask

    task automatic pulse_reset();
        cyc_wait();
        rst_n = 0;
        cyc_wait();
        rst_n = 1;
    endtask

    initial begin
        repeat (3) cyc_wait();
        check("rst_step", out_Step, 0);
        check("rst_busy", out_Busy, 0);
        check("rst_done", out_Done, 0);
        check("rst_pos", out_Position, 0);
        check("rst_dir", out_UporDown, 0);
        rst_n = 1;

        start_move(5, 3, e0);
        wait_done(100, "t1_wait");
        check("t1_nsteps", step_q.size(), 5);
        for (int k = 0; k < step_q.size() && k < 5; k++) check("t1_step_time", step_q[k] - e0, 3 * (k + 1));
        check("t1_done_time", done_edge - e0, 16);
        check("t1_pos", out_Position, 5);
        check("t1_dir", out_UporDown, 1);

        start_move(2, 0, e0);
        wait_done(100, "t2_wait");
        check("t2_nsteps", step_q.size(), 3);
        for (int k = 0; k < step_q.size() && k < 3; k++) check("t2_step_time", step_q[k] - e0, k + 1);
        check("t2_done_time", done_edge - e0, 4);
        check("t2_pos", out_Position, 2);
        check("t2_dir", out_UporDown, 0);

        start_move(2, 7, e0);
        wait_done(20, "t3_wait");
        check("t3_nsteps", step_q.size(), 0);
        check("t3_busy_seen", busy_seen, 0);
        check("t3_done_time", done_edge - e0, 1);

        start_move(200, 4, e0);
        while (cyc < e0 + 11) cyc_wait();
        abort = 1;
        cyc_wait();
        abort = 0;
        wait_done(20, "t4_wait");
        check("t4_nsteps", step_q.size(), 2);
        check("t4_pos", out_Position, 4);
        check("t4_done_time", done_edge - e0, 13);

        pulse_reset();
        check("t5_pos0", out_Position, 0);
        start_move(255, 1, e0);
        repeat (20) cyc_wait();
        target = 10;
        start = 1;
        cyc_wait();
        start = 0;
        wait_done(400, "t5_wait");
        check("t5_nsteps", step_q.size(), 255);
        check("t5_pos", out_Position, 255);
        check("t5_done_time", done_edge - e0, 256);

        pulse_reset();
        start_move(100, 1, e0);
        for (int n = 0; n < 50 && out_Position != 7; n++) cyc_wait();
        check("t6_pos7", out_Position, 7);
        rst_n = 0;
        cyc_wait();
        check("t6_rst_pos", out_Position, 0);
        check("t6_rst_busy", out_Busy, 0);
        check("t6_rst_step", out_Step, 0);
        rst_n = 1;
        start_move(1, 2, e0);
        wait_done(20, "t6_wait");
        check("t6_nsteps", step_q.size(), 1);
        if (step_q.size() > 0) check("t6_step_time", step_q[0] - e0, 2);
        check("t6_pos", out_Position, 1);

        for (int n = 0; n < 4000; n++) begin
            cyc_wait();
            rst_n = ($urandom % 400) != 0;
            start = ($urandom % 6) == 0;
            target = ($urandom % 2) ? 8'($urandom) : 8'(out_Position + 8'($urandom % 7) - 8'd3);
            period = 16'($urandom % 5);
            abort = ($urandom % 50) == 0;
        end
        cyc_wait();
        rst_n = 1; start = 0; abort = 0;
        cyc_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
